// File: rtl/bitlet_prim_decoder_index_accum.sv
// bitlet_prim_decoder_index_accum
// Multi-lane index-to-one-hot decoder with OR accumulation across beats.
// A beat flagged last closes the group: the accumulated mask and its
// popcount are registered and held under valid/ready until drained.
// Optional feature macro: BITLET_DEC_DUP_CHK_EN enables repeated-index
// detection (OUT_DUP); without it OUT_DUP is tied low.
module bitlet_prim_decoder_index_accum #(
    parameter int  W  = 16,
    parameter int  L  = 2,
    localparam int IW = (W > 1) ? $clog2(W) : 1,
    localparam int CW = $clog2(W + 1)
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            in_vld_i,
    output logic            in_rdy_o,
    input  logic [L*IW-1:0] in_idx_i,
    input  logic [L-1:0]    in_en_i,
    input  logic            in_last_i,
    output logic            out_vld_o,
    input  logic            out_rdy_i,
    output logic [W-1:0]    out_mask_o,
    output logic [CW-1:0]   out_cnt_o,
    output logic            out_dup_o
);

    typedef enum logic [0:0] {
        S_ACCUM = 1'b0,
        S_HOLD  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    mask_q, mask_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    new_s;
    logic [W-1:0]    group_s;
    logic [IW-1:0]   lane_idx_s;
    logic            in_rdy_s;
    logic            accept_s;
    logic            last_acc_s;

    // Population count of a mask; result width covers the all-ones case.
    function automatic logic [CW-1:0] popcount(input logic [W-1:0] v);
        logic [CW-1:0] cnt;
        cnt = {CW{1'b0}};
        for (int b = 0; b < W; b++) begin
            cnt = cnt + CW'(v[b]);
        end
        return cnt;
    endfunction

    // Ready depends only on the output holding register, never on IN_*.
    always_comb begin
        in_rdy_s   = (state_q == S_ACCUM) | out_rdy_i;
        accept_s   = in_vld_i & in_rdy_s;
        last_acc_s = accept_s & in_last_i;
    end

`ifdef BITLET_DEC_DUP_CHK_EN
    logic dup_beat_s;
    logic dup_acc_q, dup_acc_d;
    logic dup_q, dup_d;
`endif

    // Decode enabled in-range lanes to one-hot and OR them; out-of-range indices are dropped.
    always_comb begin
        new_s      = {W{1'b0}};
        lane_idx_s = {IW{1'b0}};
`ifdef BITLET_DEC_DUP_CHK_EN
        dup_beat_s = 1'b0;
`endif
        for (int i = 0; i < L; i++) begin
            lane_idx_s = in_idx_i[i*IW +: IW];
            if (in_en_i[i] && (32'(lane_idx_s) < 32'(W))) begin
`ifdef BITLET_DEC_DUP_CHK_EN
                // A repeat is either already in the group or an earlier lane of this beat.
                if (acc_q[lane_idx_s] || new_s[lane_idx_s]) begin
                    dup_beat_s = 1'b1;
                end else begin
                    dup_beat_s = dup_beat_s;
                end
`endif
                new_s[lane_idx_s] = 1'b1;
            end else begin
                new_s = new_s;
            end
        end
        group_s = acc_q | new_s;
    end

    // Next-state and datapath update for the ACCUM/HOLD controller.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_ACCUM: begin
                if (last_acc_s) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_HOLD: begin
                // A drain coinciding with a last-accept reloads instead of emptying.
                if (last_acc_s) begin
                    state_d = S_HOLD;
                end else if (out_rdy_i) begin
                    state_d = S_ACCUM;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_ACCUM;
            end
        endcase
        if (last_acc_s) begin
            mask_d = group_s;
            cnt_d  = popcount(group_s);
            acc_d  = {W{1'b0}};
        end else if (accept_s) begin
            acc_d  = group_s;
        end else begin
            acc_d  = acc_q;
        end
    end

    // State, accumulator and output holding registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_ACCUM;
            acc_q   <= {W{1'b0}};
            mask_q  <= {W{1'b0}};
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BITLET_DEC_DUP_CHK_EN
    // Sticky per-group duplicate flag, copied to the output with the mask.
    always_comb begin
        dup_acc_d = dup_acc_q;
        dup_d     = dup_q;
        if (last_acc_s) begin
            dup_d     = dup_acc_q | dup_beat_s;
            dup_acc_d = 1'b0;
        end else if (accept_s) begin
            dup_acc_d = dup_acc_q | dup_beat_s;
        end else begin
            dup_acc_d = dup_acc_q;
        end
    end

    // Duplicate flag registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dup_acc_q <= 1'b0;
            dup_q     <= 1'b0;
        end else begin
            dup_acc_q <= dup_acc_d;
            dup_q     <= dup_d;
        end
    end

    assign out_dup_o = dup_q;
`else
    assign out_dup_o = 1'b0;
`endif

    assign in_rdy_o   = in_rdy_s;
    assign out_vld_o  = (state_q == S_HOLD);
    assign out_mask_o = mask_q;
    assign out_cnt_o  = cnt_q;

endmodule
